// File: rtl/mem_multi_chan_model.sv
// Multi-channel tagged memory model: round-robin single accept, fixed-latency in-order responses.
// Define MEM_MODEL_STATS_EN to add saturating load/store/reject/occupancy counters.
`ifndef XLEN
`define XLEN 64
`endif

module mem_multi_chan_model #(
    parameter int NCH       = 2,
    parameter int NTAG      = 15,
    parameter int LAT       = 10,
    parameter int MEM_LINES = 8192,
    parameter int TAGW      = $clog2(NTAG + 1),
    parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NCH-1:0][1:0]       req_command,
    input  logic [NCH-1:0][`XLEN-1:0] req_addr,
    input  logic [NCH-1:0][63:0]      req_data,
    input  logic [NCH-1:0][7:0]       req_byte_en,
    output logic [NCH-1:0][TAGW-1:0]  req_response,
    output logic                      rsp_valid,
    output logic [CHW-1:0]            rsp_chan,
    output logic [TAGW-1:0]           rsp_tag,
    output logic [63:0]               rsp_data,
    output logic                      rsp_err
`ifdef MEM_MODEL_STATS_EN
    ,
    output logic [31:0]               stat_loads,
    output logic [31:0]               stat_stores,
    output logic [31:0]               stat_rejects,
    output logic [31:0]               stat_max_outstanding
`endif
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int         AW        = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

    typedef struct packed {
        logic            valid;
        logic [CHW-1:0]  chan;
        logic [TAGW-1:0] tag;
        logic [63:0]     data;
        logic            err;
    } dl_entry_t;

    // ---------------- request decode and round-robin arbitration ----------------
    logic [NCH-1:0] active;
    logic [CHW-1:0] rr_reg;
    logic [CHW-1:0] rr_next;
    logic           win_found;
    logic [CHW-1:0] win_chan;
    logic [CHW-1:0] cand_idx;
    int             cand;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_active
        // Command 3 is not a legal bus command and is ignored like BUS_NONE.
        assign active[gi] = (req_command[gi] == BUS_LOAD) || (req_command[gi] == BUS_STORE);
    end

    always_comb begin
        win_found = 1'b0;
        win_chan  = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = int'(rr_reg) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            cand_idx = CHW'(cand);
            if (!win_found && active[cand_idx]) begin
                win_found = 1'b1;
                win_chan  = cand_idx;
            end
        end
    end

    assign rr_next = (win_chan == CHW'(NCH - 1)) ? '0 : win_chan + 1'b1;

    // ---------------- tag pool ----------------
    logic [NTAG:1]   free_reg;
    logic [NTAG:1]   free_next;
    logic [TAGW-1:0] free_tag;
    logic            any_free;
    logic            accept;

    always_comb begin
        free_tag = '0;
        for (int t = NTAG; t >= 1; t--) begin
            if (free_reg[t]) begin
                free_tag = TAGW'(t);
            end
        end
    end

    assign any_free = |free_reg;
    // No accepts while reset is held so the backing array cannot be written then.
    assign accept   = win_found && any_free && reset;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_resp
        assign req_response[gi] = (accept && (win_chan == CHW'(gi))) ? free_tag : '0;
    end

    // A tag returns to the pool on the edge that retires it from the response stage,
    // so it is never re-granted in the cycle its response is visible.
    for (genvar gi = 1; gi <= NTAG; gi++) begin : g_tag
        assign free_next[gi] = (free_reg[gi] && !(accept && (free_tag == TAGW'(gi))))
                             || (rsp_valid && (rsp_tag == TAGW'(gi)));
    end

    // ---------------- winner fields ----------------
    logic [1:0]        win_cmd;
    logic [`XLEN-1:0]  win_line;
    logic [63:0]       win_wdata;
    logic [7:0]        win_byte_en;
    logic              win_oor;
    logic [AW-1:0]     win_idx;

    assign win_cmd     = req_command[win_chan];
    assign win_line    = req_addr[win_chan] >> 3;
    assign win_wdata   = req_data[win_chan];
    assign win_byte_en = req_byte_en[win_chan];
    assign win_oor     = (win_line >= `XLEN'(MEM_LINES));
    assign win_idx     = win_line[AW-1:0];

    // ---------------- backing array (not reset; preloaded by the bench) ----------------
    logic [63:0] mem [MEM_LINES];
    logic [63:0] rd_data_reg;

    always_ff @(posedge clock) begin
        if (accept && (win_cmd == BUS_STORE) && !win_oor) begin
            for (int b = 0; b < 8; b++) begin
                if (win_byte_en[b]) begin
                    mem[win_idx][b*8 +: 8] <= win_wdata[b*8 +: 8];
                end
            end
        end
        // Load data is captured at accept, so later stores cannot change it.
        if (accept) begin
            rd_data_reg <= mem[win_idx];
        end
    end

    // ---------------- accept stage, pointer and pool state ----------------
    logic            acc_valid_reg;
    logic [CHW-1:0]  acc_chan_reg;
    logic [TAGW-1:0] acc_tag_reg;
    logic            acc_err_reg;
    logic            acc_load_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_valid_reg <= 1'b0;
            acc_chan_reg  <= '0;
            acc_tag_reg   <= '0;
            acc_err_reg   <= 1'b0;
            acc_load_reg  <= 1'b0;
            rr_reg        <= '0;
            free_reg      <= '1;
        end else begin
            acc_valid_reg <= accept;
            acc_chan_reg  <= accept ? win_chan : '0;
            acc_tag_reg   <= accept ? free_tag : '0;
            acc_err_reg   <= accept && win_oor;
            acc_load_reg  <= accept && (win_cmd == BUS_LOAD) && !win_oor;
            if (accept) begin
                rr_reg <= rr_next;
            end
            free_reg <= free_next;
        end
    end

    // ---------------- delay line ----------------
    dl_entry_t dl_in;
    dl_entry_t dl_reg [LAT];

    always_comb begin
        dl_in       = '0;
        dl_in.valid = acc_valid_reg;
        dl_in.chan  = acc_chan_reg;
        dl_in.tag   = acc_tag_reg;
        dl_in.data  = acc_load_reg ? rd_data_reg : 64'd0;
        dl_in.err   = acc_err_reg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LAT; s++) begin
                dl_reg[s] <= '0;
            end
        end else begin
            dl_reg[0] <= dl_in;
            for (int s = 1; s < LAT; s++) begin
                dl_reg[s] <= dl_reg[s-1];
            end
        end
    end

    assign rsp_valid = dl_reg[LAT-1].valid;
    assign rsp_chan  = dl_reg[LAT-1].chan;
    assign rsp_tag   = dl_reg[LAT-1].tag;
    assign rsp_data  = dl_reg[LAT-1].data;
    assign rsp_err   = dl_reg[LAT-1].err;

`ifdef MEM_MODEL_STATS_EN
    // ---------------- statistics ----------------
    logic [31:0] loads_reg;
    logic [31:0] stores_reg;
    logic [31:0] rejects_reg;
    logic [31:0] max_out_reg;
    logic [31:0] rejects_inc;
    logic [31:0] outstanding;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        rejects_inc = '0;
        outstanding = '0;
        for (int c = 0; c < NCH; c++) begin
            if (active[c] && (req_response[c] == '0)) begin
                rejects_inc = rejects_inc + 32'd1;
            end
        end
        for (int t = 1; t <= NTAG; t++) begin
            if (!free_reg[t]) begin
                outstanding = outstanding + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            loads_reg   <= '0;
            stores_reg  <= '0;
            rejects_reg <= '0;
            max_out_reg <= '0;
        end else begin
            if (accept && (win_cmd == BUS_LOAD)) begin
                loads_reg <= sat_add(loads_reg, 32'd1);
            end
            if (accept && (win_cmd == BUS_STORE)) begin
                stores_reg <= sat_add(stores_reg, 32'd1);
            end
            rejects_reg <= sat_add(rejects_reg, rejects_inc);
            if (outstanding > max_out_reg) begin
                max_out_reg <= outstanding;
            end
        end
    end

    assign stat_loads           = loads_reg;
    assign stat_stores          = stores_reg;
    assign stat_rejects         = rejects_reg;
    assign stat_max_outstanding = max_out_reg;
`endif

endmodule

// File: doc/mem_multi_chan_model.md
Name: mem_multi_chan_model

Overview:
- Parametrised, cycle-accurate tagged memory model for pipeline-level benches; successor to the single-port `mem` model.
- Serves NCH independent requesters (I-cache, D-cache, prefetch) behind one round-robin accept port.
- Supports a byte-masked store path, a programmable fixed latency and a bounded tag pool.
- Responses return in order on one shared response bus, tagged with channel and transaction tag.

Parameters:
- NCH, 2, number of request channels (1..4)
- NTAG, 15, outstanding transactions; tags 1..NTAG, tag 0 = rejected
- LAT, 10, cycles from accept to response (LAT >= 1)
- MEM_LINES, 8192, 64-bit lines in the backing array
- TAGW, $clog2(NTAG+1), derived tag width
- CHW, $clog2(NCH) min 1, derived channel-index width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- req_command  in  [NCH-1:0][1:0]  per channel: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
- req_addr  in  [NCH-1:0][`XLEN-1:0]  byte address; bits [2:0] ignored
- req_data  in  [NCH-1:0][63:0]  store data
- req_byte_en  in  [NCH-1:0][7:0]  store byte mask
- req_response  out  [NCH-1:0][TAGW-1:0]  combinational; tag assigned this cycle, 0 = not accepted (retry)
- rsp_valid  out  1  registered response valid
- rsp_chan  out  CHW  channel of returning transaction
- rsp_tag  out  TAGW  tag of returning transaction
- rsp_data  out  64  load data (0 for stores and errors)
- rsp_err  out  1  address out of range

Behaviour:
- Reset (reset==0):
  - rsp_* = 0.
  - Round-robin pointer = 0.
  - Tag pool = all NTAG tags free.
  - Delay line emptied.
  - Backing array not cleared; the bench preloads it hierarchically.
- Accept (at most one per cycle):
  - Scan channels with command != NONE, starting at the RR pointer.
  - The first such channel wins if any tag is free.
  - The winner's req_response = lowest free tag; all other channels read 0.
  - On the accept posedge, the RR pointer moves to winner+1 mod NCH.
- Tags exhausted: all req_response = 0, RR pointer unchanged.
- Load accept:
  - Line index = addr >> 3.
  - Data is snapshotted at accept; a later store does not alter it.
- Store accept:
  - Bytes with byte_en=1 are written at the accept posedge.
  - The store still consumes a tag and returns rsp_data=0.
- Out of range (index >= MEM_LINES):
  - Request is accepted and tagged.
  - No write.
  - Returns rsp_err=1, rsp_data=0.
- Delay line:
  - LAT-stage shift register of {valid, chan, tag, data, err}.
  - An accept at edge N appears on rsp_* after edge N+LAT.
  - rsp_valid is high for exactly one cycle; rsp_* is held 0 otherwise.
- Tag release:
  - A tag is freed on the edge where it leaves the delay line.
  - It can be granted again in the following cycle, not the same one.
- Ordering:
  - Responses return in strict accept order.
  - Same-cycle requests are serialised by the RR pointer.
- Reset mid-operation: in-flight transactions are dropped silently; partial writes already committed remain.
- Invalid command (3): treated as NONE.

Optional Feature:
- MEM_MODEL_STATS_EN defined:
  - Adds outputs stat_loads, stat_stores, stat_rejects, stat_max_outstanding, 32 bits each.
  - Counters saturate at 2^32-1 and clear on reset.
  - stat_rejects counts channel-cycles with command != NONE and response 0.
- Undefined: these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Store/load round trip:
  - Stimulus: ch0 STORE addr 0x40, data 0x1122334455667788, byte_en 0xFF; then LOAD 0x40.
  - Response: tags 1 then 2; load returns 0x1122334455667788 exactly LAT cycles after its accept.
- Byte mask:
  - Stimulus: line 0x40 preloaded with 0; STORE data 0xFFFF...FF, byte_en 0x0F; then LOAD 0x40.
  - Response: 0x00000000FFFFFFFF.
- Round robin:
  - Stimulus: ch0 and ch1 issue LOAD every cycle.
  - Response: winners alternate 0,1,0,1; loser reads 0 and retries; rsp_chan follows the same order.
- Tag exhaustion:
  - Stimulus: NTAG=4, LAT=10; 6 back-to-back loads on ch0.
  - Response: tags 1–4, then 0 until the first return; tag 1 is granted again one cycle after it returns.
- Out of range:
  - Stimulus: LOAD addr MEM_LINES*8.
  - Response: accepted; rsp_err=1, rsp_data=0 after LAT.
- Async reset:
  - Stimulus: assert reset between clock edges with 3 loads in flight.
  - Response: rsp_valid drops immediately; no responses after deassert; stored data preserved.
